regfile: RTL and testbench

Architectural register file for the single-cycle datapath. Sits directly upstream of the ALU and supplies its `a` and `b` operands. Holds 32 × 32-bit general-purpose registers, with register 0 hardwired to zero. Provides two combinational read ports and one clocked write port that takes the write-back result (ALU `y` or memory read data).

---
 rtl/regfile.sv | 71 +++++++
 tb/tb_regfile.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Architectural register file: 2^DEPTH_LOG2 x WIDTH, r0 hardwired to zero,
// two combinational read ports, one clocked write port. Optional macro: REGFILE_BYPASS_EN.
module regfile #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DEPTH_LOG2-1:0] a1,
   input  logic [DEPTH_LOG2-1:0] a2,
   input  logic [DEPTH_LOG2-1:0] a3,
   input  logic                  we3,
   input  logic [WIDTH-1:0]      wd3,
   output logic [WIDTH-1:0]      rd1,
   output logic [WIDTH-1:0]      rd2
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Entry 0 has no storage; the read muxes below fall through to zero for it.
   logic [WIDTH-1:0] mem [1:DEPTH-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (we3 && (a3 == DEPTH_LOG2'(i))) begin
               mem[i] <= wd3;
            end
         end
      end
   end

   always_comb begin
      rd1 = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (a1 == DEPTH_LOG2'(i)) begin
            rd1 = mem[i];
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (we3 && (a3 != '0) && (a3 == a1)) begin
         rd1 = wd3;
      end
`endif
      if (reset) begin
         rd1 = '0;
      end
   end

   always_comb begin
      rd2 = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (a2 == DEPTH_LOG2'(i)) begin
            rd2 = mem[i];
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (we3 && (a3 != '0) && (a3 == a2)) begin
         rd2 = wd3;
      end
`endif
      if (reset) begin
         rd2 = '0;
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed literal cases plus randomized traffic
// compared every cycle against an array model of the architectural registers.
module tb_regfile;

   logic        clk;
   logic        reset;
   logic [4:0]  a1, a2, a3;
   logic        we3;
   logic [31:0] wd3;
   logic [31:0] rd1, rd2;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   logic [31:0] model [32];

   regfile #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
      .clk(clk), .reset(reset),
      .a1(a1), .a2(a2), .a3(a3),
      .we3(we3), .wd3(wd3),
      .rd1(rd1), .rd2(rd2)
   );

   // clock / reset
   initial clk = 0;
   always #5 clk = ~clk;

   // reference model: architectural state
   always @(posedge clk) begin
      if (!reset && we3 && a3 != 0) model[a3] = wd3;
   end
   always @(posedge reset) begin
      for (int i = 0; i < 32; i++) model[i] = 0;
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] addr);
      if (reset) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (we3 && a3 != 0 && a3 == addr) return wd3;
`endif
      if (addr == 0) return 32'h0;
      return model[addr];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // compare process
   always @(negedge clk) begin
      if (chk_en) begin
         check("rd1_model", rd1, exp_rd(a1));
         check("rd2_model", rd2, exp_rd(a2));
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
      we3 = we; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2;
   endtask

   task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
      set_in(1, wa, wd, a1, a2);
      step();
      we3 = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 0;
      reset = 1;
      set_in(0, 0, 0, 5, 31);
      step(); step();
      check("reset_rd1", rd1, 32'h0);
      check("reset_rd2", rd2, 32'h0);
      reset = 0;
      chk_en = 1;

      // reset clear mid-cycle
      write_reg(5, 32'hDEADBEEF);
      a1 = 5; #1;
      check("r5_written", rd1, 32'hDEADBEEF);
      #1 reset = 1;
      #1 check("async_reset_rd1", rd1, 32'h0);
      step();
      reset = 0;
      #1 check("r5_after_reset", rd1, 32'h0);

      // basic write/read and we3=0 hold
      write_reg(7, 32'h12345678);
      a1 = 7; a2 = 7; #1;
      check("r7_rd1", rd1, 32'h12345678);
      check("r7_rd2", rd2, 32'h12345678);
      set_in(0, 7, 32'hFFFFFFFF, 7, 7);
      step();
      check("r7_hold", rd1, 32'h12345678);

      // r0 hardwired
      set_in(1, 0, 32'hFFFFFFFF, 0, 0);
      step();
      we3 = 0; #1;
      check("r0_rd1", rd1, 32'h0);
      check("r0_rd2", rd2, 32'h0);

      // dual port
      write_reg(1, 32'h3);
      write_reg(2, 32'h5);
      a1 = 1; a2 = 2; #1;
      check("dual_rd1", rd1, 32'h3);
      check("dual_rd2", rd2, 32'h5);
      check("dual_sum", rd1 + rd2, 32'h8);

      // same-cycle hazard
      write_reg(9, 32'h11111111);
      set_in(1, 9, 32'h22222222, 9, 9);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("hazard_pre", rd1, 32'h22222222);
`else
      check("hazard_pre", rd1, 32'h11111111);
`endif
      step();
      we3 = 0; #1;
      check("hazard_post", rd1, 32'h22222222);

      // sweep
      for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h1000 + i);
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i); a2 = 5'(31 - i); #1;
         check("sweep_rd1", rd1, (i == 0) ? 32'h0 : 32'h1000 + i);
         check("sweep_rd2", rd2, (i == 31) ? 32'h0 : 32'h1000 + (31 - i));
      end

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step();
         reset = ($urandom_range(0, 63) == 0);
         we3 = 1'($urandom_range(0, 1));
         a3 = 5'($urandom_range(0, 31));
         wd3 = $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      end
      step();
      reset = 0; we3 = 0;
      step();
      chk_en = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
